// File: rtl/fp_serial_tx.sv
// Serial transmitter for the packed {sign, exponent, significand} byte: start, 8 data bits LSB first, optional
// even parity (enabled by defining FP_SERIAL_TX_PARITY_EN), stop. A one-entry hold register decouples the converter.
module fp_serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in,
    input  logic [2:0] e_in,
    input  logic [3:0] f_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready is low while the
    // hold register is occupied, so the producer must keep s_in/e_in/f_in stable until that edge.

`ifdef FP_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    state_t     state, state_n;
    logic [7:0] hold_reg;
    logic       hold_full;
    logic [7:0] shift_reg;
    logic [7:0] baud_cnt;
    logic [2:0] bit_cnt;
    logic       baud_last;
    logic       load;
    logic       bit_adv;
    logic       tx_n;
    logic       accept;
`ifdef FP_SERIAL_TX_PARITY_EN
    logic       parity_r;
`endif

    assign in_ready  = ~hold_full;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign accept    = in_valid & in_ready;
    assign baud_last = (baud_cnt == 8'(CLKS_PER_BIT - 1));

    always_comb begin
        state_n = state;
        load    = 1'b0;
        bit_adv = 1'b0;
        tx_n    = 1'b1;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_last) state_n = DATA;
            end
            DATA: begin
                tx_n = shift_reg[0];
                if (baud_last) begin
                    bit_adv = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef FP_SERIAL_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef FP_SERIAL_TX_PARITY_EN
            PARITY: begin
                tx_n = parity_r;
                if (baud_last) state_n = STOP;
            end
`endif
            STOP: begin
                // A waiting word chains straight into the next start bit, no idle cycle between frames.
                if (baud_last) begin
                    if (hold_full) begin
                        load    = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line trails the state register by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            hold_reg  <= 8'h00;
            hold_full <= 1'b0;
            shift_reg <= 8'h00;
            baud_cnt  <= 8'h00;
            bit_cnt   <= 3'd0;
`ifdef FP_SERIAL_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tx    <= tx_n;

            if (accept) begin
                hold_reg  <= {s_in, e_in, f_in};
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load)         shift_reg <= hold_reg;
            else if (bit_adv) shift_reg <= {1'b0, shift_reg[7:1]};

`ifdef FP_SERIAL_TX_PARITY_EN
            if (load) parity_r <= ^hold_reg;
`endif

            if (state_n != state || bit_adv || state == IDLE) baud_cnt <= 8'h00;
            else                                              baud_cnt <= baud_cnt + 8'h01;

            if (bit_adv) bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_fp_serial_tx.sv
// Directed bench for fp_serial_tx: driver pushes expected bytes, a line monitor decodes frames from tx and compares.
module tb_fp_serial_tx;

    localparam int C = 4;
`ifdef FP_SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_in = 1'b0;
    logic [2:0] e_in = 3'd0;
    logic [3:0] f_in = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] state_dbg;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         frame_starts[$];
    bit         abort_mon = 1'b0;
    bit         in_frame = 1'b0;

    fp_serial_tx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .e_in      (e_in),
        .f_in      (f_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // driver: offer one byte until accepted, return the accept-edge cycle number
    task automatic send(input logic [7:0] b, output int acc_cyc);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 500) begin
            @(negedge clk);
            {s_in, e_in, f_in} = b;
            in_valid = 1'b1;
            ok = in_ready;
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc = cyc;
        if (ok) exp_q.push_back(b);
        else    check("send accept timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && !in_frame && !busy && tx === 1'b1) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("drain timeout", 32'd0, 32'd1);
    endtask

    // monitor: decode frames off the line and score against exp_q
    initial begin : monitor
        logic [7:0]  exp_b;
        logic [10:0] bits;
        bit          ok_frame;
        bit          have_exp;
        forever begin
            @(negedge clk);
            if (!abort_mon && tx === 1'b0) begin
                in_frame = 1'b1;
                frame_starts.push_back(cyc);
                ok_frame = 1'b1;
                have_exp = (exp_q.size() != 0);
                exp_b = 8'h00;
                if (have_exp) exp_b = exp_q.pop_front();
                else          check("unexpected frame", 32'd1, 32'd0);
                bits = '0;
                for (int k = 0; k < NB; k++) begin
                    repeat ((k == 0) ? C / 2 : C) begin
                        @(negedge clk);
                        if (abort_mon || rst) ok_frame = 1'b0;
                    end
                    bits[k] = tx;
                end
                repeat (C - C / 2 - 1) begin
                    @(negedge clk);
                    if (abort_mon || rst) ok_frame = 1'b0;
                end
                if (ok_frame && have_exp) begin
                    check("start bit", 32'(bits[0]), 32'd0);
                    check("data byte", 32'(bits[8:1]), 32'(exp_b));
`ifdef FP_SERIAL_TX_PARITY_EN
                    check("parity bit", 32'(bits[9]), 32'(^exp_b));
`endif
                    check("stop bit", 32'(bits[NB-1]), 32'd1);
                end
                in_frame = 1'b0;
            end
        end
    end

    logic [7:0] bp_tbl [8] = '{8'h4B, 8'hFF, 8'h80, 8'h01, 8'h7E, 8'hA5, 8'h3C, 8'hC3};

    initial begin : stim
        int acc, acc2, nf, guard, ns, nacc, lows;
        bit ok;

        // reset with in_valid high: accept must be ignored
        rst = 1'b1;
        in_valid = 1'b1;
        {s_in, e_in, f_in} = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset state", 32'(state_dbg), 32'd0);
        repeat (10) @(negedge clk);
        check("no accept during reset", 32'(busy), 32'd0);
        check("no frame after reset", 32'(frame_starts.size()), 32'd0);

        // single frame 0x4B (S=0 E=4 F=11), start-bit latency accept+2
        nf = frame_starts.size();
        send(8'h4B, acc);
        check("in_ready low after accept", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("tx high at accept+1", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx low at accept+2", 32'(tx), 32'd0);
        wait_done();
        check("single frame count", 32'(frame_starts.size() - nf), 32'd1);
        if (frame_starts.size() > nf) check("start latency", 32'(frame_starts[nf] - acc), 32'd2);

        // parity-relevant bytes
        send(8'hFF, acc);
        wait_done();
        send(8'h80, acc);
        wait_done();

        // back-to-back: second word offered mid-frame
        nf = frame_starts.size();
        send(8'h12, acc);
        repeat (10) @(negedge clk);
        send(8'h35, acc2);
        check("in_ready low with hold full", 32'(in_ready), 32'd0);
        wait_done();
        check("b2b frame count", 32'(frame_starts.size() - nf), 32'd2);
        if (frame_starts.size() >= nf + 2)
            check("b2b spacing", 32'(frame_starts[nf+1] - frame_starts[nf]), 32'(NB * C));

        // backpressure: in_valid held, data changing every cycle
        nf = frame_starts.size();
        nacc = 0;
        guard = 0;
        while (nacc < 5 && guard < 1000) begin
            @(negedge clk);
            {s_in, e_in, f_in} = bp_tbl[guard % 8];
            in_valid = 1'b1;
            ok = in_ready;
            @(posedge clk);
            if (ok) begin
                exp_q.push_back(bp_tbl[guard % 8]);
                nacc++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("backpressure accepts", 32'(nacc), 32'd5);
        wait_done();
        check("backpressure frame count", 32'(frame_starts.size() - nf), 32'd5);

        // reset in DATA bit 3 of a frame with the hold register full
        nf = frame_starts.size();
        send(8'hC3, acc);
        guard = 0;
        while (frame_starts.size() == nf && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("abort frame started", 32'(frame_starts.size() - nf), 32'd1);
        send(8'h5A, acc2);
        ns = (frame_starts.size() > nf) ? frame_starts[nf] : cyc;
        guard = 0;
        while (cyc < ns + 17 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("hold full before reset", 32'(in_ready), 32'd0);
        abort_mon = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort tx", 32'(tx), 32'd1);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        nf = frame_starts.size();
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("line idle after abort", 32'(lows), 32'd0);
        check("no frame after abort", 32'(frame_starts.size() - nf), 32'd0);
        abort_mon = 1'b0;
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_serial_tx.md
FP_SERIAL_TX -- requirements
Module: fp_serial_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16: clk cycles per serial bit period, legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port s_in, input, 1 bit: sign of the floating-point word from the converter stage.
REQ-005 SHALL have port e_in, input, 3 bits: exponent of the floating-point word.
REQ-006 SHALL have port f_in, input, 4 bits: significand of the floating-point word.
REQ-007 SHALL have port in_valid, input, 1 bit: s_in/e_in/f_in hold a word to send.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pack the payload byte as {s_in, e_in, f_in}: bit7 = S, bits6:4 = E, bits3:0 = F.
REQ-012 SHALL contain a one-entry holding register; in_ready = NOT hold_full, driven from a register.
REQ-013 SHALL accept a word on any rising edge where in_valid AND in_ready, loading the hold register and setting hold_full on that edge.
REQ-014 SHALL ignore s_in/e_in/f_in on edges without an accept; held data SHALL not change until transferred.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx = 1; if hold_full, SHALL move the hold register into the shift register, clear hold_full and enter START on the next edge.
REQ-017 START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles; 3-bit bit counter runs 0..7 and wraps to 0 on exit.
REQ-019 After bit 7, SHALL go to PARITY when PARITY_EN is defined, else to STOP.
REQ-020 STOP: tx = 1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP with hold_full, SHALL transfer hold to shift register and enter START directly, with no IDLE cycle (back-to-back frames).
REQ-022 At the end of STOP with hold empty, SHALL enter IDLE.
REQ-023 Baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state or bit change, and never run freely in IDLE.
REQ-024 Latency: for an accept on edge N from IDLE with hold empty, tx SHALL go low immediately after edge N+2.
REQ-025 A transfer and a new accept on the same edge SHALL not occur, because in_ready is low while hold_full; the new word is accepted on the next edge at the earliest.
REQ-026 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity.

Reset
REQ-027 rst high at a rising edge SHALL force state = IDLE, tx = 1, busy = 0, hold_full = 0, in_ready = 1, and both counters = 0.
REQ-028 rst mid-frame SHALL abort the frame and discard both the shift register and the hold register contents; tx SHALL be high on the first cycle after the reset edge.
REQ-029 While rst is high, accepts SHALL be ignored.

Configuration
REQ-030 Macro FP_SERIAL_TX_PARITY_EN defined: PARITY state SHALL send one even-parity bit (XOR of the 8 payload bits) for CLKS_PER_BIT cycles.
REQ-031 Macro FP_SERIAL_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-032 Reset check: CLKS_PER_BIT=4, hold rst for 2 cycles -> tx=1, busy=0, in_ready=1.
REQ-033 Single frame: S=0, E=4, F=11 (byte 0x4B) -> tx sequence 0,1,1,0,1,0,0,1,0,1, each bit for 4 cycles; start edge at accept+2.
REQ-034 Parity build: byte 0x4B -> parity bit 0; byte 0xFF (S=1, E=7, F=15) -> parity bit 0; byte 0x80 -> parity bit 1.
REQ-035 Back-to-back: second word offered during the first frame -> in_ready low after the second accept, and its start bit immediately follows the first stop bit (frames are 40 cycles apart, no idle gap).
REQ-036 Backpressure: in_valid held high with changing data while the hold register is full -> only accepted words are transmitted, none lost or duplicated.
REQ-037 Reset mid-DATA, asserted at bit 3 of frame 1 with the hold register full -> tx=1 next cycle, no further frames sent, in_ready=1.
